stage_ma_hs: RTL and testbench

- Parametrised memory-access pipeline stage. Sits between the EX/MA pipeline register and the writeback stage.
- Drives a data-memory port with a variable-latency req/ack handshake and supports byte, half and word accesses with sign/zero extension.
- Forwards writeback data into store data, stalls the pipeline while an access is outstanding, and registers results into an MA/WB register.

---
 rtl/stage_ma_hs_if.sv | 21 ++
 rtl/stage_ma_hs.sv | 276 +++++++++++++++++++++++++++
 tb/tb_stage_ma_hs.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_ma_hs_if.sv
`default_nettype none
// ============================================================================
// Module : stage_ma_hs_if
// Data-memory request/acknowledge port between the MA stage and memory.
// Rev    : 1.0
// ============================================================================
interface stage_ma_hs_if #(
  parameter int WIDTH = 32
);
  logic               req;
  logic               we;
  logic [WIDTH-1:0]   addr;
  logic [WIDTH/8-1:0] be;
  logic [WIDTH-1:0]   wdata;
  logic               ack;
  logic [WIDTH-1:0]   rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/stage_ma_hs.sv
`default_nettype none
// ============================================================================
// Module : stage_ma_hs
// Memory-access pipeline stage: variable-latency data-memory handshake,
// sub-word load/store lane handling, and the MA/WB pipeline register.
// Rev    : 1.0
// ============================================================================
module stage_ma_hs #(
  parameter int WIDTH   = 32,
  parameter int RADDR_W = 5,
  parameter int WB_W    = 3,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WB_W-1:0]    i_ma_WB,
  input  logic [1:0]         i_ma_MA,
  input  logic [1:0]         i_ma_size,
  input  logic               i_ma_signed,
  input  logic [WIDTH-1:0]   i_ma_ALU_rslt,
  input  logic [WIDTH-1:0]   i_ma_Rs2_val,
  input  logic [WIDTH-1:0]   i_ma_PC,
  input  logic [RADDR_W-1:0] i_ma_Rdst,
  input  logic [WIDTH-1:0]   i_ma_mux_wb,
  input  logic               i_OP1_MemS,
  input  logic               i_ma_flush,
  input  logic               i_ma_stall,
  stage_ma_hs_if.master      mem,
  output logic               o_ma_busy,
  output logic               o_miss,
  output logic [WIDTH-1:0]   o_ma_PC,
  output logic [RADDR_W-1:0] o_ma_Rds,
  output logic [WIDTH-1:0]   o_ALU_rsl,
  output logic [WIDTH-1:0]   o_ma_mem_out,
  output logic [WB_W-1:0]    o_ma_WB
);

  localparam int C_BE_W  = WIDTH / 8;
  localparam int C_OFF_W = $clog2(C_BE_W);
  localparam int C_CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_WAIT = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic               kill_q, kill_d;
  logic               we_q, we_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic [C_BE_W-1:0]  be_q, be_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic [C_OFF_W-1:0] off_q, off_d;
  logic [1:0]         size_q, size_d;
  logic               sgn_q, sgn_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [RADDR_W-1:0] rdst_q, rdst_d;
  logic [WIDTH-1:0]   alu_q, alu_d;
  logic [WB_W-1:0]    wb_q, wb_d;

  logic [WIDTH-1:0]   ma_pc_q, ma_pc_d;
  logic [RADDR_W-1:0] ma_rds_q, ma_rds_d;
  logic [WIDTH-1:0]   ma_alu_q, ma_alu_d;
  logic [WIDTH-1:0]   ma_mem_q, ma_mem_d;
  logic [WB_W-1:0]    ma_wb_q, ma_wb_d;

  logic               w_is_mem, w_is_store, w_aligned, w_issue, w_misalign;
  logic               w_in_wait, w_timeout, w_req;
  logic [C_OFF_W-1:0] w_off;
  logic [WIDTH-1:0]   w_fwd, w_addr, w_wdata, w_ext;
  logic [C_BE_W-1:0]  w_be;

  // Lane select then sign/zero extend; half offsets are already even here.
  function automatic logic [WIDTH-1:0] f_extract(
    input logic [WIDTH-1:0]   word,
    input logic [C_OFF_W-1:0] off,
    input logic [1:0]         size,
    input logic               sgn
  );
    logic [WIDTH-1:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'b00:   f_extract = {{(WIDTH-8){sgn & sh[7]}}, sh[7:0]};
      2'b01:   f_extract = {{(WIDTH-16){sgn & sh[15]}}, sh[15:0]};
      default: f_extract = sh;
    endcase
  endfunction

  always_comb begin
    w_off      = i_ma_ALU_rslt[C_OFF_W-1:0];
    w_fwd      = i_OP1_MemS ? i_ma_mux_wb : i_ma_Rs2_val;
    w_addr     = {i_ma_ALU_rslt[WIDTH-1:C_OFF_W], {C_OFF_W{1'b0}}};
    w_is_mem   = (i_ma_MA == 2'b01) || (i_ma_MA == 2'b10);
    w_is_store = (i_ma_MA == 2'b10);
    case (i_ma_size)
      2'b00: begin
        w_aligned = 1'b1;
        w_be      = C_BE_W'(1) << w_off;
        w_wdata   = {C_BE_W{w_fwd[7:0]}};
      end
      2'b01: begin
        w_aligned = ~w_off[0];
        w_be      = C_BE_W'(3) << w_off;
        w_wdata   = {(WIDTH/16){w_fwd[15:0]}};
      end
      default: begin
        w_aligned = (w_off == '0);
        w_be      = '1;
        w_wdata   = w_fwd;
      end
    endcase

    // A stalled MA/WB register cannot accept a result, so the access waits.
    w_issue    = (state_q == C_IDLE) && w_is_mem && w_aligned && !i_ma_stall && !rst;
    w_misalign = (state_q == C_IDLE) && w_is_mem && !w_aligned && !i_ma_stall && !rst;
    w_in_wait  = (state_q == C_WAIT) && !rst;
    w_timeout  = w_in_wait && (cnt_q == C_CNT_W'(TIMEOUT));
    w_req      = w_issue || (w_in_wait && !w_timeout);

    w_ext = w_issue ? f_extract(mem.rdata, w_off, i_ma_size, i_ma_signed)
                    : f_extract(mem.rdata, off_q, size_q, sgn_q);
  end

  assign mem.req   = w_req;
  assign mem.we    = w_req && (w_issue ? w_is_store : we_q);
  assign mem.addr  = w_req ? (w_issue ? w_addr  : addr_q)  : '0;
  assign mem.be    = w_req ? (w_issue ? w_be    : be_q)    : '0;
  assign mem.wdata = w_req ? (w_issue ? w_wdata : wdata_q) : '0;

  assign o_ma_busy = (w_issue && !mem.ack) || w_in_wait;
  assign o_miss    = w_misalign || w_timeout;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kill_d  = kill_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    rdata_d = rdata_q;
    pc_d    = pc_q;
    rdst_d  = rdst_q;
    alu_d   = alu_q;
    wb_d    = wb_q;
    case (state_q)
      C_IDLE: begin
        if (w_issue) begin
          cnt_d   = C_CNT_W'(1);
          kill_d  = i_ma_flush;
          we_d    = w_is_store;
          addr_d  = w_addr;
          be_d    = w_be;
          wdata_d = w_wdata;
          off_d   = w_off;
          size_d  = i_ma_size;
          sgn_d   = i_ma_signed;
          pc_d    = i_ma_PC;
          rdst_d  = i_ma_Rdst;
          alu_d   = i_ma_ALU_rslt;
          wb_d    = i_ma_WB;
          if (mem.ack) begin
            state_d = C_DONE;
            rdata_d = w_is_store ? '0 : w_ext;
          end else begin
            state_d = C_WAIT;
          end
        end
      end
      C_WAIT: begin
        if (i_ma_flush) kill_d = 1'b1;
        if (w_timeout) begin
          state_d = C_DONE;
          rdata_d = '0;
        end else if (mem.ack) begin
          state_d = C_DONE;
          rdata_d = we_q ? '0 : w_ext;
        end else begin
          cnt_d = cnt_q + C_CNT_W'(1);
        end
      end
      C_DONE: begin
        if (!i_ma_stall || i_ma_flush) state_d = C_IDLE;
      end
      default: state_d = C_IDLE;
    endcase
  end

  // MA/WB register: flush beats stall/busy, which beat a normal load.
  always_comb begin
    ma_pc_d  = ma_pc_q;
    ma_rds_d = ma_rds_q;
    ma_alu_d = ma_alu_q;
    ma_mem_d = ma_mem_q;
    ma_wb_d  = ma_wb_q;
    if (i_ma_flush || (state_q == C_DONE && kill_q)) begin
      ma_pc_d  = '0;
      ma_rds_d = '0;
      ma_alu_d = '0;
      ma_mem_d = '0;
      ma_wb_d  = '0;
    end else if (state_q == C_DONE) begin
      if (!i_ma_stall) begin
        ma_pc_d  = pc_q;
        ma_rds_d = rdst_q;
        ma_alu_d = alu_q;
        ma_mem_d = rdata_q;
        ma_wb_d  = wb_q;
      end
    end else if (state_q == C_IDLE && !i_ma_stall && !w_issue) begin
      ma_pc_d  = i_ma_PC;
      ma_rds_d = i_ma_Rdst;
      ma_alu_d = i_ma_ALU_rslt;
      ma_mem_d = '0;
      ma_wb_d  = i_ma_WB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= C_IDLE;
      cnt_q    <= '0;
      kill_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      off_q    <= '0;
      size_q   <= '0;
      sgn_q    <= 1'b0;
      rdata_q  <= '0;
      pc_q     <= '0;
      rdst_q   <= '0;
      alu_q    <= '0;
      wb_q     <= '0;
      ma_pc_q  <= '0;
      ma_rds_q <= '0;
      ma_alu_q <= '0;
      ma_mem_q <= '0;
      ma_wb_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      kill_q   <= kill_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      off_q    <= off_d;
      size_q   <= size_d;
      sgn_q    <= sgn_d;
      rdata_q  <= rdata_d;
      pc_q     <= pc_d;
      rdst_q   <= rdst_d;
      alu_q    <= alu_d;
      wb_q     <= wb_d;
      ma_pc_q  <= ma_pc_d;
      ma_rds_q <= ma_rds_d;
      ma_alu_q <= ma_alu_d;
      ma_mem_q <= ma_mem_d;
      ma_wb_q  <= ma_wb_d;
    end
  end

  assign o_ma_PC      = ma_pc_q;
  assign o_ma_Rds     = ma_rds_q;
  assign o_ALU_rsl    = ma_alu_q;
  assign o_ma_mem_out = ma_mem_q;
  assign o_ma_WB      = ma_wb_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_ma_hs.sv
`default_nettype none
// ============================================================================
// Module : tb_stage_ma_hs
// Directed bench for stage_ma_hs with hand-computed expected values.
// Rev    : 1.0
// ============================================================================
module tb_stage_ma_hs;

  localparam int WIDTH   = 32;
  localparam int RADDR_W = 5;
  localparam int WB_W    = 3;
  localparam int TIMEOUT = 15;

  logic               clk;
  logic               rst;
  logic [WB_W-1:0]    i_ma_WB;
  logic [1:0]         i_ma_MA;
  logic [1:0]         i_ma_size;
  logic               i_ma_signed;
  logic [WIDTH-1:0]   i_ma_ALU_rslt;
  logic [WIDTH-1:0]   i_ma_Rs2_val;
  logic [WIDTH-1:0]   i_ma_PC;
  logic [RADDR_W-1:0] i_ma_Rdst;
  logic [WIDTH-1:0]   i_ma_mux_wb;
  logic               i_OP1_MemS;
  logic               i_ma_flush;
  logic               i_ma_stall;
  logic               o_ma_busy;
  logic               o_miss;
  logic [WIDTH-1:0]   o_ma_PC;
  logic [RADDR_W-1:0] o_ma_Rds;
  logic [WIDTH-1:0]   o_ALU_rsl;
  logic [WIDTH-1:0]   o_ma_mem_out;
  logic [WB_W-1:0]    o_ma_WB;

  int n_checks = 0;
  int n_errors = 0;
  int busy_n;
  int req_n;
  int miss_n;

  stage_ma_hs_if #(.WIDTH(WIDTH)) mem_if ();

  stage_ma_hs #(
    .WIDTH(WIDTH), .RADDR_W(RADDR_W), .WB_W(WB_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_ma_WB(i_ma_WB), .i_ma_MA(i_ma_MA), .i_ma_size(i_ma_size),
    .i_ma_signed(i_ma_signed), .i_ma_ALU_rslt(i_ma_ALU_rslt),
    .i_ma_Rs2_val(i_ma_Rs2_val), .i_ma_PC(i_ma_PC), .i_ma_Rdst(i_ma_Rdst),
    .i_ma_mux_wb(i_ma_mux_wb), .i_OP1_MemS(i_OP1_MemS),
    .i_ma_flush(i_ma_flush), .i_ma_stall(i_ma_stall),
    .mem(mem_if),
    .o_ma_busy(o_ma_busy), .o_miss(o_miss),
    .o_ma_PC(o_ma_PC), .o_ma_Rds(o_ma_Rds), .o_ALU_rsl(o_ALU_rsl),
    .o_ma_mem_out(o_ma_mem_out), .o_ma_WB(o_ma_WB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] ma, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] pc);
    i_ma_MA       = ma;
    i_ma_size     = sz;
    i_ma_signed   = sgn;
    i_ma_ALU_rslt = addr;
    i_ma_PC       = pc;
  endtask

  // Drive ack on request cycle ack_k (0 = issue cycle); ends in the DONE cycle.
  task automatic access(input int ack_k, input logic [31:0] rd);
    busy_n = 0;
    for (int k = 0; k <= ack_k; k++) begin
      mem_if.ack   = (k == ack_k);
      mem_if.rdata = (k == ack_k) ? rd : 32'h0;
      #1;
      if (o_ma_busy) busy_n++;
      next_cycle();
    end
    mem_if.ack   = 1'b0;
    mem_if.rdata = 32'h0;
    i_ma_MA      = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    i_ma_WB = 3'b101; i_ma_Rdst = 5'd7;
    i_ma_MA = 2'b00; i_ma_size = 2'b10; i_ma_signed = 1'b0;
    i_ma_ALU_rslt = 32'h0; i_ma_Rs2_val = 32'h5555_5555; i_ma_PC = 32'h0;
    i_ma_mux_wb = 32'h0; i_OP1_MemS = 1'b0; i_ma_flush = 1'b0; i_ma_stall = 1'b0;
    mem_if.ack = 1'b0; mem_if.rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req",  {31'd0, mem_if.req}, 32'd0);
    check_eq("rst_busy", {31'd0, o_ma_busy}, 32'd0);
    check_eq("rst_pc",   o_ma_PC, 32'd0);
    check_eq("rst_mem",  o_ma_mem_out, 32'd0);
    rst = 1'b0;

    // Word load, ack on the third request cycle
    set_op(2'b01, 2'b10, 1'b0, 32'h100, 32'h40);
    #1;
    check_eq("wl_req",  {31'd0, mem_if.req}, 32'd1);
    check_eq("wl_addr", mem_if.addr, 32'h100);
    check_eq("wl_be",   {28'd0, mem_if.be}, 32'hF);
    check_eq("wl_we",   {31'd0, mem_if.we}, 32'd0);
    access(2, 32'hDEAD_BEEF);
    check_eq("wl_busy_cycles", busy_n, 32'd3);
    check_eq("wl_done_busy", {31'd0, o_ma_busy}, 32'd0);
    next_cycle();
    check_eq("wl_mem", o_ma_mem_out, 32'hDEAD_BEEF);
    check_eq("wl_pc",  o_ma_PC, 32'h40);
    check_eq("wl_alu", o_ALU_rsl, 32'h100);
    check_eq("wl_rds", {27'd0, o_ma_Rds}, 32'd7);
    check_eq("wl_wb",  {29'd0, o_ma_WB}, 32'd5);

    // Signed and unsigned byte loads at offset 3
    set_op(2'b01, 2'b00, 1'b1, 32'h103, 32'h44);
    #1;
    check_eq("sb_be",   {28'd0, mem_if.be}, 32'h8);
    check_eq("sb_addr", mem_if.addr, 32'h100);
    access(1, 32'h8012_3456);
    next_cycle();
    check_eq("sb_mem", o_ma_mem_out, 32'hFFFF_FF80);
    set_op(2'b01, 2'b00, 1'b0, 32'h103, 32'h48);
    access(0, 32'h8012_3456);
    check_eq("ub_busy_cycles", busy_n, 32'd0);
    next_cycle();
    check_eq("ub_mem", o_ma_mem_out, 32'h0000_0080);

    // Half store with forwarded data; lanes held stable while waiting
    set_op(2'b10, 2'b01, 1'b0, 32'h202, 32'h50);
    i_OP1_MemS = 1'b1; i_ma_mux_wb = 32'h1234_ABCD;
    #1;
    check_eq("hs_addr",  mem_if.addr, 32'h200);
    check_eq("hs_be",    {28'd0, mem_if.be}, 32'hC);
    check_eq("hs_wdata", mem_if.wdata, 32'hABCD_ABCD);
    check_eq("hs_we",    {31'd0, mem_if.we}, 32'd1);
    next_cycle();
    i_OP1_MemS = 1'b0; i_ma_mux_wb = 32'h0;
    #1;
    check_eq("hs_hold_wdata", mem_if.wdata, 32'hABCD_ABCD);
    check_eq("hs_hold_be",    {28'd0, mem_if.be}, 32'hC);
    check_eq("hs_hold_we",    {31'd0, mem_if.we}, 32'd1);
    mem_if.ack = 1'b1;
    next_cycle();
    mem_if.ack = 1'b0; i_ma_MA = 2'b00;
    next_cycle();
    check_eq("hs_mem", o_ma_mem_out, 32'h0);
    check_eq("hs_alu", o_ALU_rsl, 32'h202);

    // Misaligned half load
    set_op(2'b01, 2'b01, 1'b0, 32'h101, 32'h60);
    #1;
    check_eq("mis_req",  {31'd0, mem_if.req}, 32'd0);
    check_eq("mis_miss", {31'd0, o_miss}, 32'd1);
    check_eq("mis_busy", {31'd0, o_ma_busy}, 32'd0);
    next_cycle();
    check_eq("mis_mem", o_ma_mem_out, 32'h0);
    check_eq("mis_alu", o_ALU_rsl, 32'h101);
    check_eq("mis_pc",  o_ma_PC, 32'h60);
    i_ma_MA = 2'b00;
    #1;
    check_eq("mis_miss_clr", {31'd0, o_miss}, 32'd0);

    // Timeout: no ack ever
    next_cycle();
    set_op(2'b01, 2'b10, 1'b0, 32'h300, 32'h70);
    req_n = 0; miss_n = 0;
    for (int k = 0; k < TIMEOUT; k++) begin
      #1;
      if (mem_if.req) req_n++;
      if (o_miss) miss_n++;
      next_cycle();
    end
    i_ma_MA = 2'b00;
    #1;
    check_eq("to_req_cycles", req_n, TIMEOUT);
    check_eq("to_early_miss", miss_n, 32'd0);
    check_eq("to_req_drop",   {31'd0, mem_if.req}, 32'd0);
    check_eq("to_miss",       {31'd0, o_miss}, 32'd1);
    next_cycle();
    check_eq("to_done_miss", {31'd0, o_miss}, 32'd0);
    check_eq("to_done_busy", {31'd0, o_ma_busy}, 32'd0);
    next_cycle();
    check_eq("to_mem", o_ma_mem_out, 32'h0);
    check_eq("to_pc",  o_ma_PC, 32'h70);

    // Flush while waiting: result discarded
    set_op(2'b01, 2'b10, 1'b0, 32'h400, 32'h88);
    #1;
    check_eq("fl_req", {31'd0, mem_if.req}, 32'd1);
    next_cycle();
    i_ma_flush = 1'b1;
    #1;
    check_eq("fl_busy", {31'd0, o_ma_busy}, 32'd1);
    next_cycle();
    i_ma_flush = 1'b0;
    check_eq("fl_pc_cleared", o_ma_PC, 32'h0);
    mem_if.ack = 1'b1; mem_if.rdata = 32'h1234_5678;
    next_cycle();
    mem_if.ack = 1'b0; mem_if.rdata = 32'h0; i_ma_MA = 2'b00;
    next_cycle();
    check_eq("fl_pc",  o_ma_PC, 32'h0);
    check_eq("fl_mem", o_ma_mem_out, 32'h0);
    check_eq("fl_alu", o_ALU_rsl, 32'h0);
    check_eq("fl_rds", {27'd0, o_ma_Rds}, 32'd0);
    check_eq("fl_wb",  {29'd0, o_ma_WB}, 32'd0);

    // Reset mid-access, then a late ack
    set_op(2'b01, 2'b10, 1'b0, 32'h500, 32'h90);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; i_ma_MA = 2'b00;
    #1;
    check_eq("rw_req", {31'd0, mem_if.req}, 32'd0);
    mem_if.ack = 1'b1; mem_if.rdata = 32'hFFFF_FFFF;
    #1;
    check_eq("rw_late_busy", {31'd0, o_ma_busy}, 32'd0);
    check_eq("rw_late_req",  {31'd0, mem_if.req}, 32'd0);
    next_cycle();
    mem_if.ack = 1'b0; mem_if.rdata = 32'h0;
    check_eq("rw_mem", o_ma_mem_out, 32'h0);

    // Signed half load at offset 2 after recovery
    set_op(2'b01, 2'b01, 1'b1, 32'h602, 32'hA0);
    #1;
    check_eq("sh_be",   {28'd0, mem_if.be}, 32'hC);
    check_eq("sh_addr", mem_if.addr, 32'h600);
    access(0, 32'hBEEF_1234);
    next_cycle();
    check_eq("sh_mem", o_ma_mem_out, 32'hFFFF_BEEF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
